// File: rtl/exec_sequencer_pkg.sv
// Shared encodings and defaults for the multi-cycle execute sequencer.
// Unit classes match the decoder's UnitSel field; states are the sequencer FSM.
package exec_sequencer_pkg;

    localparam logic [1:0] UNIT_ALU   = 2'b00;
    localparam logic [1:0] UNIT_MUL32 = 2'b01;
    localparam logic [1:0] UNIT_MUL64 = 2'b10;
    localparam logic [1:0] UNIT_FPU   = 2'b11;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int FPU_CYCLES_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALU_ACK,
        ST_RUN,
        ST_WB_LO,
        ST_WB_HI
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A latency of 1 still needs a one-bit counter to hold the zero value.
    function automatic int count_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/exec_sequencer_latency_counter.sv
// Loadable down-counter with a zero flag, used to time the multiplier/FPU latency.
// Priority is clear > load > decrement; it saturates at zero instead of wrapping.
module latency_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Execute sequencer: launches the multiplier or FPU, waits out its fixed latency
// while stalling the main FSM, then issues one or two register writeback beats.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int FPU_CYCLES = FPU_CYCLES_DEF,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       UnitSel,
    input  logic [3:0]       RdLo,
    input  logic [3:0]       RdHi,
    input  logic             Flush,
    input  logic             ClrErr,
    input  logic [WIDTH-1:0] MulLo,
    input  logic [WIDTH-1:0] MulHi,
    input  logic [WIDTH-1:0] FpuRes,
    output logic             MulStart,
    output logic             FpuStart,
    output logic             Busy,
    output logic             WbValid,
    output logic [3:0]       WbAddr,
    output logic [WIDTH-1:0] WbData,
    output logic             Done,
    output logic             ErrOverlap
);

    localparam int CW = count_width(max_int(MUL_CYCLES, FPU_CYCLES));
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] FPU_LOAD = CW'(FPU_CYCLES - 1);

    state_e           state;
    state_e           next_state;
    logic [1:0]       cls;
    logic [3:0]       rd_lo;
    logic [3:0]       rd_hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             first;
    logic             err;
    logic             accept;
    logic             launch;
    logic             cnt_zero;
    logic [CW-1:0]    load_value;

    // Flush wins over a same-cycle Start, so a flushed request is never accepted.
    assign accept     = (state == ST_IDLE) && Start && !Flush;
    assign launch     = accept && (UnitSel != UNIT_ALU);
    assign load_value = (UnitSel == UNIT_FPU) ? FPU_LOAD : MUL_LOAD;

    latency_counter #(
        .CW(CW)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (Flush),
        .load      (launch),
        .load_value(load_value),
        .dec       (state == ST_RUN),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (UnitSel == UNIT_ALU) ? ST_ALU_ACK : ST_RUN;
                end
            end
            ST_ALU_ACK: next_state = ST_IDLE;
            ST_RUN: begin
                if (cnt_zero) begin
                    next_state = ST_WB_LO;
                end
            end
            ST_WB_LO:   next_state = (cls == UNIT_MUL64) ? ST_WB_HI : ST_IDLE;
            ST_WB_HI:   next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
        if (Flush) begin
            next_state = ST_IDLE;
        end
    end

    // Request capture, result latch and the sticky overlap flag (set beats clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls   <= UNIT_ALU;
            rd_lo <= '0;
            rd_hi <= '0;
            lo    <= '0;
            hi    <= '0;
            first <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (launch) begin
                cls   <= UnitSel;
                rd_lo <= RdLo;
                rd_hi <= RdHi;
                first <= 1'b1;
            end else if (state == ST_RUN) begin
                first <= 1'b0;
            end

            if ((state == ST_RUN) && cnt_zero && !Flush) begin
                if (cls == UNIT_FPU) begin
                    lo <= FpuRes;
                    hi <= '0;
                end else begin
                    lo <= MulLo;
                    hi <= MulHi;
                end
            end

            if (Start && (state != ST_IDLE)) begin
                err <= 1'b1;
            end else if (ClrErr) begin
                err <= 1'b0;
            end
        end
    end

    // Outputs depend only on registered state, so reset forces them low at once.
    always_comb begin
        MulStart = 1'b0;
        FpuStart = 1'b0;
        Busy     = 1'b0;
        WbValid  = 1'b0;
        WbAddr   = '0;
        WbData   = '0;
        Done     = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_ALU_ACK: begin
                Busy = 1'b1;
                Done = 1'b1;
            end
            ST_RUN: begin
                Busy     = 1'b1;
                MulStart = first && (cls != UNIT_FPU);
                FpuStart = first && (cls == UNIT_FPU);
            end
            ST_WB_LO: begin
                Busy    = 1'b1;
                WbValid = 1'b1;
                WbAddr  = rd_lo;
                WbData  = lo;
                Done    = (cls != UNIT_MUL64);
            end
            ST_WB_HI: begin
                Busy    = 1'b1;
                WbValid = 1'b1;
                WbAddr  = rd_hi;
                WbData  = hi;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign ErrOverlap = err;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with hand-computed cycle-by-cycle expectations.
module tb_exec_sequencer;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  UnitSel;
    logic [3:0]  RdLo;
    logic [3:0]  RdHi;
    logic        Flush;
    logic        ClrErr;
    logic [31:0] MulLo;
    logic [31:0] MulHi;
    logic [31:0] FpuRes;
    logic        MulStart;
    logic        FpuStart;
    logic        Busy;
    logic        WbValid;
    logic [3:0]  WbAddr;
    logic [31:0] WbData;
    logic        Done;
    logic        ErrOverlap;

    int passed = 0;
    int total  = 0;

    exec_sequencer #(
        .MUL_CYCLES(4),
        .FPU_CYCLES(6),
        .WIDTH     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .UnitSel   (UnitSel),
        .RdLo      (RdLo),
        .RdHi      (RdHi),
        .Flush     (Flush),
        .ClrErr    (ClrErr),
        .MulLo     (MulLo),
        .MulHi     (MulHi),
        .FpuRes    (FpuRes),
        .MulStart  (MulStart),
        .FpuStart  (FpuStart),
        .Busy      (Busy),
        .WbValid   (WbValid),
        .WbAddr    (WbAddr),
        .WbData    (WbData),
        .Done      (Done),
        .ErrOverlap(ErrOverlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [1:0] sel,
                                 input logic [3:0] lo, input logic [3:0] hi);
        Start   = start;
        UnitSel = sel;
        RdLo    = lo;
        RdHi    = hi;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},    32'(Busy),     32'd0);
        checkOutput({tag, "_wbvalid"}, 32'(WbValid),  32'd0);
        checkOutput({tag, "_done"},    32'(Done),     32'd0);
        checkOutput({tag, "_mulstart"},32'(MulStart), 32'd0);
        checkOutput({tag, "_fpustart"},32'(FpuStart), 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        Flush  = 1'b0;
        ClrErr = 1'b0;
        MulLo  = 32'hDEAD_0000;
        MulHi  = 32'hDEAD_1111;
        FpuRes = 32'hDEAD_2222;
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);

        #1;
        checkIdle("in_reset");
        checkOutput("in_reset_err", 32'(ErrOverlap), 32'd0);
        stepCycle();
        reset = 1'b1;
        stepCycle();
        checkIdle("post_reset");
        checkOutput("post_reset_wbaddr", 32'(WbAddr), 32'd0);
        checkOutput("post_reset_wbdata", WbData, 32'd0);

        // ALU: Done one cycle after Start, no writeback, no launch
        applyStimulus(1'b1, 2'b00, 4'd1, 4'd0);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        checkOutput("alu_done",     32'(Done),     32'd1);
        checkOutput("alu_busy",     32'(Busy),     32'd1);
        checkOutput("alu_wbvalid",  32'(WbValid),  32'd0);
        checkOutput("alu_mulstart", 32'(MulStart), 32'd0);
        checkOutput("alu_fpustart", 32'(FpuStart), 32'd0);
        stepCycle();
        checkIdle("alu_after");

        // MUL32, RdLo=4, product valid only during t+4
        applyStimulus(1'b1, 2'b01, 4'd4, 4'd9);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        checkOutput("m32_t1_mulstart", 32'(MulStart), 32'd1);
        checkOutput("m32_t1_fpustart", 32'(FpuStart), 32'd0);
        checkOutput("m32_t1_busy",     32'(Busy),     32'd1);
        stepCycle();
        checkOutput("m32_t2_mulstart", 32'(MulStart), 32'd0);
        checkOutput("m32_t2_busy",     32'(Busy),     32'd1);
        stepCycle();
        checkOutput("m32_t3_wbvalid",  32'(WbValid),  32'd0);
        stepCycle();
        MulLo = 32'h0000_002A;
        MulHi = 32'h0000_0000;
        checkOutput("m32_t4_busy",     32'(Busy),     32'd1);
        checkOutput("m32_t4_wbvalid",  32'(WbValid),  32'd0);
        checkOutput("m32_t4_done",     32'(Done),     32'd0);
        stepCycle();
        MulLo = 32'hDEAD_0000;
        MulHi = 32'hDEAD_1111;
        checkOutput("m32_t5_wbvalid", 32'(WbValid), 32'd1);
        checkOutput("m32_t5_wbaddr",  32'(WbAddr),  32'd4);
        checkOutput("m32_t5_wbdata",  WbData,       32'h0000_002A);
        checkOutput("m32_t5_done",    32'(Done),    32'd1);
        checkOutput("m32_t5_busy",    32'(Busy),    32'd1);
        stepCycle();
        checkIdle("m32_t6");

        // MUL64, RdLo=2 RdHi=3, product 0x00000001_FFFFFFFE
        applyStimulus(1'b1, 2'b10, 4'd2, 4'd3);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        checkOutput("m64_t1_mulstart", 32'(MulStart), 32'd1);
        stepCycle();
        stepCycle();
        stepCycle();
        MulLo = 32'hFFFF_FFFE;
        MulHi = 32'h0000_0001;
        stepCycle();
        MulLo = 32'hDEAD_0000;
        MulHi = 32'hDEAD_1111;
        checkOutput("m64_lo_wbvalid", 32'(WbValid), 32'd1);
        checkOutput("m64_lo_wbaddr",  32'(WbAddr),  32'd2);
        checkOutput("m64_lo_wbdata",  WbData,       32'hFFFF_FFFE);
        checkOutput("m64_lo_done",    32'(Done),    32'd0);
        stepCycle();
        checkOutput("m64_hi_wbvalid", 32'(WbValid), 32'd1);
        checkOutput("m64_hi_wbaddr",  32'(WbAddr),  32'd3);
        checkOutput("m64_hi_wbdata",  WbData,       32'h0000_0001);
        checkOutput("m64_hi_done",    32'(Done),    32'd1);
        stepCycle();
        checkIdle("m64_after");

        // FPU, RdLo=7, result valid only during t+6
        applyStimulus(1'b1, 2'b11, 4'd7, 4'd0);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        checkOutput("fpu_t1_fpustart", 32'(FpuStart), 32'd1);
        checkOutput("fpu_t1_mulstart", 32'(MulStart), 32'd0);
        for (int i = 2; i <= 6; i++) begin
            stepCycle();
            if (i == 6) FpuRes = 32'h3F80_0000;
            checkOutput($sformatf("fpu_t%0d_wbvalid", i), 32'(WbValid), 32'd0);
            checkOutput($sformatf("fpu_t%0d_busy", i), 32'(Busy), 32'd1);
        end
        stepCycle();
        FpuRes = 32'hDEAD_2222;
        checkOutput("fpu_t7_wbvalid", 32'(WbValid), 32'd1);
        checkOutput("fpu_t7_wbaddr",  32'(WbAddr),  32'd7);
        checkOutput("fpu_t7_wbdata",  WbData,       32'h3F80_0000);
        checkOutput("fpu_t7_done",    32'(Done),    32'd1);
        stepCycle();
        checkIdle("fpu_after");

        // Overlapping Start during RUN: ignored, sticky error, cleared by ClrErr
        applyStimulus(1'b1, 2'b01, 4'd5, 4'd0);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        stepCycle();
        applyStimulus(1'b1, 2'b11, 4'd9, 4'd0);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        checkOutput("ovl_t3_err", 32'(ErrOverlap), 32'd1);
        stepCycle();
        MulLo  = 32'h0000_0055;
        checkOutput("ovl_t4_err_held", 32'(ErrOverlap), 32'd1);
        ClrErr = 1'b1;
        stepCycle();
        ClrErr = 1'b0;
        MulLo  = 32'hDEAD_0000;
        checkOutput("ovl_t5_err_clr", 32'(ErrOverlap), 32'd0);
        checkOutput("ovl_t5_wbvalid", 32'(WbValid),    32'd1);
        checkOutput("ovl_t5_wbaddr",  32'(WbAddr),     32'd5);
        checkOutput("ovl_t5_wbdata",  WbData,          32'h0000_0055);
        checkOutput("ovl_t5_done",    32'(Done),       32'd1);
        stepCycle();
        checkIdle("ovl_after");

        // Flush in the second RUN cycle of MUL64: nothing written, no Done
        applyStimulus(1'b1, 2'b10, 4'd2, 4'd3);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        stepCycle();
        Flush = 1'b1;
        stepCycle();
        Flush = 1'b0;
        checkOutput("flush_busy", 32'(Busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("flush_wbvalid_%0d", i), 32'(WbValid), 32'd0);
            checkOutput($sformatf("flush_done_%0d", i),    32'(Done),    32'd0);
            stepCycle();
        end

        // Flush overrides a same-cycle Start in IDLE
        applyStimulus(1'b1, 2'b01, 4'd6, 4'd0);
        Flush = 1'b1;
        stepCycle();
        Flush = 1'b0;
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        checkOutput("flush_start_busy",     32'(Busy),       32'd0);
        checkOutput("flush_start_mulstart", 32'(MulStart),   32'd0);
        checkOutput("flush_start_err",      32'(ErrOverlap), 32'd0);

        // MUL32 to r15, then async reset in WB_LO
        applyStimulus(1'b1, 2'b01, 4'd15, 4'd0);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
        stepCycle();
        stepCycle();
        stepCycle();
        MulLo = 32'h1234_5678;
        stepCycle();
        checkOutput("r15_wbvalid", 32'(WbValid), 32'd1);
        checkOutput("r15_wbaddr",  32'(WbAddr),  32'd15);
        checkOutput("r15_wbdata",  WbData,       32'h1234_5678);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_busy",    32'(Busy),    32'd0);
        checkOutput("async_rst_wbvalid", 32'(WbValid), 32'd0);
        checkOutput("async_rst_done",    32'(Done),    32'd0);
        checkOutput("async_rst_wbaddr",  32'(WbAddr),  32'd0);
        reset = 1'b1;
        stepCycle();
        checkIdle("after_async_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execute sequencer for the multicycle ARM-style core. Sits beside the main FSM and decoder.
- On a start request it launches the iterative multiplier or the FPU and counts that unit's fixed latency, stalling the FSM (Busy) while it waits.
- It then sequences register writeback: one beat for 32-bit results, two beats (RdLo then RdHi) for long multiplies.
- ALU-class requests are acknowledged in one cycle, so the FSM sees a uniform Start/Done handshake.

Parameters:
- MUL_CYCLES, 4, multiplier latency in cycles from MulStart to a valid product; must be >= 1.
- FPU_CYCLES, 6, FPU latency in cycles from FpuStart to a valid result; must be >= 1.
- WIDTH, 32, datapath word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Start  in  1  request from the main FSM execute state; sampled only in IDLE.
- UnitSel  in  2  request class: 00 ALU, 01 MUL32, 10 MUL64 (long), 11 FPU.
- RdLo  in  4  destination register for the result / low word; captured on accept.
- RdHi  in  4  destination register for the high word (MUL64 only); captured on accept.
- Flush  in  1  synchronous abort.
- ClrErr  in  1  clears ErrOverlap.
- MulLo  in  WIDTH  multiplier low word.
- MulHi  in  WIDTH  multiplier high word.
- FpuRes  in  WIDTH  FPU result.
- MulStart  out  1  one-cycle launch pulse to the multiplier.
- FpuStart  out  1  one-cycle launch pulse to the FPU.
- Busy  out  1  stall to the main FSM.
- WbValid  out  1  register-file write enable for the current writeback beat.
- WbAddr  out  4  writeback register number.
- WbData  out  WIDTH  writeback data.
- Done  out  1  completion pulse.
- ErrOverlap  out  1  sticky flag: a Start arrived while not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; counter=0; captured regs=0; every output 0.
- States: IDLE, ALU_ACK, RUN, WB_LO, WB_HI.
- IDLE: Busy=0.
  - Start & UnitSel=00 -> ALU_ACK.
  - Start & UnitSel in {01,10,11} -> RUN. Same edge: capture UnitSel, RdLo, RdHi; load counter with (MUL_CYCLES-1) or (FPU_CYCLES-1).
- ALU_ACK: Busy=1, Done=1, WbValid=0 (the ALU result is written via the normal path); next state IDLE.
- RUN: Busy=1.
  - First RUN cycle only: MulStart=1 (class 01/10) or FpuStart=1 (class 11).
  - Counter decrements each RUN cycle.
  - When counter=0: latch MulLo/MulHi (MUL) or FpuRes (FPU) into internal lo/hi registers; next state WB_LO.
- WB_LO: Busy=1, WbValid=1, WbAddr=RdLo, WbData=lo.
  - Class MUL64 -> WB_HI.
  - Otherwise Done=1 and next state IDLE.
- WB_HI: Busy=1, WbValid=1, WbAddr=RdHi, WbData=hi, Done=1; next state IDLE.
- Latency (Start high in cycle t):
  - Launch pulse at t+1.
  - Unit result must be valid by cycle t+L (L = unit latency); it is sampled at t+L.
  - MUL32/FPU: WbValid and Done at t+L+1.
  - MUL64: low beat at t+L+1, high beat with Done at t+L+2.
  - ALU: Done at t+1.
- Outputs WbValid, WbAddr, WbData, Done, MulStart, FpuStart, Busy are decoded from registered state only; no combinational path from inputs.
- Start while not IDLE: ignored; ErrOverlap set next edge.
  - ErrOverlap is cleared by ClrErr or reset.
  - Set and clear in the same cycle: set wins.
- Flush (any state): next state IDLE and the counter clears.
  - A pending writeback beat is dropped; Done is not pulsed.
  - Flush overrides a same-cycle Start in IDLE (the request is dropped, no ErrOverlap).
- MUL64 with RdLo=RdHi: both beats are issued; the high word lands last and wins.
- WbAddr=15 is written like any other register; PC redirect is handled outside this block.
- Reset mid-operation: immediate return to IDLE; outputs go to 0 asynchronously.

Decomposition:
- Shared package holds:
  - UnitSel encodings (UNIT_ALU=2'b00, UNIT_MUL32=2'b01, UNIT_MUL64=2'b10, UNIT_FPU=2'b11).
  - State encodings.
  - MUL_CYCLES/FPU_CYCLES defaults.
- One natural sub-module: latency_counter.
  - Loadable down-counter with a zero flag; width = clog2(max(MUL_CYCLES,FPU_CYCLES)).
  - Instantiated once in exec_sequencer.

Test Plan:
- Reset released, idle -> all outputs 0; Start=1, UnitSel=00 -> Done=1 exactly one cycle later, WbValid=0, no launch pulse.
- MUL32 Start, RdLo=4, MulLo=0x0000002A valid at t+4 -> MulStart at t+1; Busy t+1..t+5; WbValid/Done at t+5 with WbAddr=4, WbData=0x2A.
- MUL64 Start, RdLo=2, RdHi=3, product 0x00000001_FFFFFFFE -> beat t+5 writes r2=0xFFFFFFFE; beat t+6 writes r3=0x00000001 with Done.
- FPU Start, RdLo=7, FpuRes=0x3F800000 -> FpuStart at t+1; WbValid/Done at t+7 with WbAddr=7, WbData=0x3F800000.
- Start during RUN -> ignored, ErrOverlap=1 and held; ClrErr -> 0; original op completes unchanged.
- Flush in the 2nd RUN cycle of MUL64 -> IDLE next cycle, no WbValid, no Done; async reset asserted in WB_LO -> Busy=WbValid=0 immediately.
